// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: branch condition codes,
// sequencer states and the condition evaluator used by the branch resolver.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ALWAYS = 2'd0,
        Z      = 2'd1,
        NZ     = 2'd2,
        NEG    = 2'd3
    } br_cond_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } seq_state_t;

    // True when the branch condition holds for the current ALU flags.
    function automatic logic cond_eval(input br_cond_t cond, input logic flag_z, input logic flag_n);
        logic res;
        case (cond)
            ALWAYS:  res = 1'b1;
            Z:       res = flag_z;
            NZ:      res = ~flag_z;
            NEG:     res = flag_n;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/br_resolve.sv
// Branch resolver: evaluates the condition code against the ALU flags and
// forms the PC-relative target. Purely combinational; the target wraps
// modulo 2^PC_W with no overflow indication.
module br_resolve
    import pc_seq_pkg::*;
#(
    parameter int PC_W  = 9,
    parameter int OFF_W = 6
) (
    input  logic [PC_W-1:0]  i_pc,
    input  logic [OFF_W-1:0] i_off,
    input  br_cond_t         i_cond,
    input  logic             i_flag_z,
    input  logic             i_flag_n,
    output logic             o_cond,
    output logic [PC_W-1:0]  o_target
);

    logic [PC_W-1:0] w_off_ext;

    // Sign-extend the offset to the PC width so a plain add handles both directions.
    assign w_off_ext = {{(PC_W-OFF_W){i_off[OFF_W-1]}}, i_off};
    assign o_target  = i_pc + w_off_ext;
    assign o_cond    = cond_eval(i_cond, i_flag_z, i_flag_n);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: runs one program from a requested entry address
// (IDLE -> LOAD -> RUN -> HALT), drives branch/taken/target to the PC, and
// reports completion, timeout and per-run cycle / taken-branch statistics.
//
// Handshake: req_start is a single-cycle request sampled on posedge clk; it is
// accepted only in IDLE or HALT and ignored in LOAD/RUN. done rises on the edge
// after the last RUN cycle and stays high until the next accepted req_start;
// timeout is meaningful only while done is high.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W    = 9,
    parameter int OFF_W   = 6,
    parameter int CNT_W   = 16,
    parameter int MAX_CYC = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_start,
    input  logic [PC_W-1:0]  req_addr,
    input  logic [PC_W-1:0]  pc_in,
    input  logic             is_branch,
    input  br_cond_t         br_cond,
    input  logic [OFF_W-1:0] br_off,
    input  logic             flag_z,
    input  logic             flag_n,
    input  logic             halt,
    output logic             start,
    output logic [PC_W-1:0]  start_addr,
    output logic             branch,
    output logic             taken,
    output logic [PC_W-1:0]  target,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] tkn_cnt,
    output seq_state_t       dbg_state
);

    // Last RUN cycle allowed before a forced halt; compared against the pre-increment count.
    localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(MAX_CYC - 1);

    seq_state_t       r_state;
    seq_state_t       w_next_state;
    logic [PC_W-1:0]  r_start_addr;
    logic             r_done;
    logic             r_timeout;
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_tkn_cnt;

    logic             w_cond;
    logic [PC_W-1:0]  w_target;
    logic             w_run;
    logic             w_accept;
    logic             w_limit;
    logic             w_branch;
    logic             w_taken;

    br_resolve #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_br_resolve (
        .i_pc     (pc_in),
        .i_off    (br_off),
        .i_cond   (br_cond),
        .i_flag_z (flag_z),
        .i_flag_n (flag_n),
        .o_cond   (w_cond),
        .o_target (w_target)
    );

    assign w_run    = (r_state == RUN);
    assign w_accept = req_start && ((r_state == IDLE) || (r_state == HALT));
    assign w_limit  = (r_cyc_cnt == LP_LIMIT);
    // A halting instruction never branches, even if it also decodes as a branch.
    assign w_branch = w_run && is_branch && !halt;
    assign w_taken  = w_branch && w_cond;

    // State register; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; halt takes priority over the cycle limit.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (req_start) w_next_state = LOAD;
            LOAD:    w_next_state = RUN;
            RUN:     if (halt || w_limit) w_next_state = HALT;
            HALT:    if (req_start) w_next_state = LOAD;
            default: w_next_state = IDLE;
        endcase
    end

    // Entry address, completion/timeout status and run statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_addr <= '0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_cyc_cnt    <= '0;
            r_tkn_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_start_addr <= req_addr;
                r_done       <= 1'b0;
                r_timeout    <= 1'b0;
            end
            if (r_state == LOAD) begin
                r_cyc_cnt <= '0;
                r_tkn_cnt <= '0;
            end
            if (w_run) begin
                if (r_cyc_cnt != '1) begin
                    r_cyc_cnt <= r_cyc_cnt + 1'b1;
                end
                if (w_taken && (r_tkn_cnt != '1)) begin
                    r_tkn_cnt <= r_tkn_cnt + 1'b1;
                end
                if (halt) begin
                    r_done    <= 1'b1;
                    r_timeout <= 1'b0;
                end else if (w_limit) begin
                    r_done    <= 1'b1;
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    // PC is held at the entry address whenever the sequencer is not running.
    assign start      = !w_run;
    assign start_addr = r_start_addr;
    assign branch     = w_branch;
    assign taken      = w_taken;
    assign target     = w_run ? w_target : pc_in;
    assign done       = r_done;
    assign timeout    = r_timeout;
    assign cyc_cnt    = r_cyc_cnt;
    assign tkn_cnt    = r_tkn_cnt;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Closed-loop bench: pc_sequencer drives a behavioural program counter; the
// instruction at each PC comes from small decode memories. A reference model
// walks the program at instruction level and queues the expected PC trace and
// the expected end-of-run report; a monitor compares as the DUT runs.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int PC_W   = 9;
    localparam int OFF_W  = 6;
    localparam int CNT_W  = 16;
    localparam int TB_MAX = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_start;
    logic [PC_W-1:0]  req_addr;
    logic [PC_W-1:0]  pc;
    logic             is_branch;
    br_cond_t         br_cond;
    logic [OFF_W-1:0] br_off;
    logic             flag_z;
    logic             flag_n;
    logic             halt;
    logic             start;
    logic [PC_W-1:0]  start_addr;
    logic             branch;
    logic             taken;
    logic [PC_W-1:0]  target;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] tkn_cnt;
    seq_state_t       dbg_state;

    // decode memories indexed by PC
    logic             br_m   [512];
    logic [1:0]       cond_m [512];
    logic [OFF_W-1:0] off_m  [512];
    logic             halt_m [512];
    logic             z_m    [512];
    logic             n_m    [512];

    // expected trace entries {taken, pc}; expected reports {timeout, start_addr, cyc, tkn}
    logic [PC_W:0]             pc_q[$];
    logic [1+PC_W+2*CNT_W-1:0] exp_q[$];

    int total = 0;
    int bad   = 0;

    pc_sequencer #(
        .PC_W    (PC_W),
        .OFF_W   (OFF_W),
        .CNT_W   (CNT_W),
        .MAX_CYC (TB_MAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_start  (req_start),
        .req_addr   (req_addr),
        .pc_in      (pc),
        .is_branch  (is_branch),
        .br_cond    (br_cond),
        .br_off     (br_off),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .halt       (halt),
        .start      (start),
        .start_addr (start_addr),
        .branch     (branch),
        .taken      (taken),
        .target     (target),
        .done       (done),
        .timeout    (timeout),
        .cyc_cnt    (cyc_cnt),
        .tkn_cnt    (tkn_cnt),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- program counter model ----------------
    always @(posedge clk) begin
        if (start)      pc <= start_addr;
        else if (taken) pc <= target;
        else            pc <= pc + 1'b1;
    end

    assign is_branch = br_m[pc];
    assign br_cond   = br_cond_t'(cond_m[pc]);
    assign br_off    = off_m[pc];
    assign halt      = halt_m[pc];
    assign flag_z    = z_m[pc];
    assign flag_n    = n_m[pc];

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) begin
            br_m[i] = 1'b0; cond_m[i] = 2'd0; off_m[i] = '0;
            halt_m[i] = 1'b0; z_m[i] = 1'b0; n_m[i] = 1'b0;
        end
    endtask

    task automatic set_br(input int a, input logic [1:0] c, input int off, input logic z);
        br_m[a] = 1'b1; cond_m[a] = c; off_m[a] = OFF_W'(off); z_m[a] = z;
    endtask

    // Instruction-level walk of the program from entry address a.
    task automatic model(input logic [PC_W-1:0] a);
        logic [PC_W-1:0] p;
        int cyc, tkn;
        bit cond, tk, to;
        p = a; cyc = 0; tkn = 0; to = 0;
        while (1) begin
            cyc++;
            case (cond_m[p])
                2'd0: cond = 1'b1;
                2'd1: cond = z_m[p];
                2'd2: cond = !z_m[p];
                default: cond = n_m[p];
            endcase
            tk = !halt_m[p] && br_m[p] && cond;
            pc_q.push_back({tk, p});
            if (tk) tkn++;
            if (halt_m[p]) break;
            if (cyc == TB_MAX) begin to = 1; break; end
            if (tk) p = p + {{(PC_W-OFF_W){off_m[p][OFF_W-1]}}, off_m[p]};
            else    p = p + 1'b1;
        end
        exp_q.push_back({to, a, CNT_W'(cyc), CNT_W'(tkn)});
    endtask

    // Issue one run and wait for completion; inject re-requests during LOAD/RUN if asked.
    task automatic do_run(input logic [PC_W-1:0] a, input bit inject);
        @(negedge clk);
        req_start = 1'b1; req_addr = a;
        model(a);
        @(negedge clk);
        check("done_clear_on_start", done, 1'b0);
        if (inject) begin
            req_addr = 9'h1AB;
            @(negedge clk);
            @(negedge clk);
        end
        req_start = 1'b0;
        req_addr  = PC_W'($urandom_range(0, 511));
        for (int i = 0; i < 100; i++) begin
            if (done) break;
            @(negedge clk);
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL done_wait: done never rose for start 0x%0h", a);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic prev_done;
        logic [PC_W:0] et;
        logic [1+PC_W+2*CNT_W-1:0] er;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (dbg_state == RUN) begin
                    if (pc_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL run_pc: RUN cycle at pc 0x%0h with no expected entry", pc);
                    end else begin
                        et = pc_q.pop_front();
                        check("run_pc", pc, et[PC_W-1:0]);
                        check("taken", taken, et[PC_W]);
                    end
                    if (halt) check("branch_on_halt", {branch, taken}, 2'b00);
                end
                if (done && !prev_done) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL report: done rose with no expected report");
                    end else begin
                        er = exp_q.pop_front();
                        check("timeout", timeout, er[1+PC_W+2*CNT_W-1]);
                        check("start_addr", start_addr, er[PC_W+2*CNT_W-1:2*CNT_W]);
                        check("cyc_cnt", cyc_cnt, er[2*CNT_W-1:CNT_W]);
                        check("tkn_cnt", tkn_cnt, er[CNT_W-1:0]);
                        check("trace_drained", pc_q.size(), 0);
                    end
                end
                prev_done = done;
            end else begin
                prev_done = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; req_start = 1'b0; req_addr = '0;
        clear_mem();
        repeat (3) @(negedge clk);
        check("rst_state", dbg_state, IDLE);
        check("rst_start", start, 1'b1);
        check("rst_start_addr", start_addr, 0);
        check("rst_done", {done, timeout}, 2'b00);
        check("rst_counters", {cyc_cnt, tkn_cnt}, 0);
        check("rst_branch", {branch, taken}, 2'b00);
        #2 rst_n = 1'b1;

        // straight-line run to a halt, with re-requests ignored in LOAD/RUN
        clear_mem(); halt_m[9'h014] = 1'b1;
        do_run(9'h010, 1'b1);

        // conditional branch back, taken then not taken
        clear_mem(); set_br(9'h020, 2'd1, -4, 1'b1); halt_m[9'h01C] = 1'b1;
        do_run(9'h01E, 1'b0);
        clear_mem(); set_br(9'h020, 2'd1, -4, 1'b0); halt_m[9'h021] = 1'b1;
        do_run(9'h01E, 1'b0);

        // target wraps in both directions
        clear_mem(); set_br(9'h1FE, 2'd0, 5, 1'b0); halt_m[9'h003] = 1'b1;
        do_run(9'h1FE, 1'b0);
        clear_mem(); set_br(9'h002, 2'd0, -3, 1'b0); halt_m[9'h1FF] = 1'b1;
        do_run(9'h002, 1'b0);

        // cycle limit, and halt on the limit cycle
        clear_mem();
        do_run(9'h080, 1'b0);
        halt_m[9'h08F] = 1'b1;
        do_run(9'h080, 1'b0);

        // halt together with an always-taken branch
        clear_mem(); set_br(9'h0A2, 2'd0, 7, 1'b0); halt_m[9'h0A2] = 1'b1;
        do_run(9'h0A0, 1'b0);

        // reset in the middle of a run
        clear_mem();
        @(negedge clk);
        req_start = 1'b1; req_addr = 9'h040;
        model(9'h040);
        @(negedge clk);
        req_start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_rst_state", dbg_state, IDLE);
        check("midrun_rst_start", start, 1'b1);
        check("midrun_rst_counters", {cyc_cnt, tkn_cnt}, 0);
        check("midrun_rst_done", done, 1'b0);
        pc_q.delete(); exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        halt_m[9'h045] = 1'b1;
        do_run(9'h043, 1'b0);

        // random programs
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 512; i++) begin
                halt_m[i] = ($urandom_range(0, 9) == 0);
                br_m[i]   = ($urandom_range(0, 3) == 0);
                cond_m[i] = 2'($urandom_range(0, 3));
                off_m[i]  = OFF_W'($urandom_range(0, 63));
                z_m[i]    = 1'($urandom_range(0, 1));
                n_m[i]    = 1'($urandom_range(0, 1));
            end
            do_run(PC_W'($urandom_range(0, 511)), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("queues_empty", pc_q.size() + exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // hard time limit
    initial begin
        #400000;
        $display("FAIL time_limit: bench did not finish");
        $fatal(1);
    end

endmodule
